// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD page buffer: FSM encoding,
// page geometry and image-ROM address field layout.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ACK,
        ST_STREAM
    } lcd_state_e;

    localparam int LCD_PAGE_BYTES = 64;
    localparam int LCD_PAGES      = 8;

    localparam int IMG_W  = 4;
    localparam int PAGE_W = 3;
    localparam int ROW_W  = 3;
    localparam int COLB_W = 3;
    localparam int IDX_W  = ROW_W + COLB_W;
    localparam int ADDR_W = IMG_W + PAGE_W;
    localparam int ROM_NAT_W = IMG_W + PAGE_W + IDX_W;

    // Fetch index is row-major: idx = {row, byte}.
    function automatic logic [ROM_NAT_W-1:0] rom_addr_f(
        input logic [IMG_W-1:0]  img,
        input logic [PAGE_W-1:0] page,
        input logic [IDX_W-1:0]  idx
    );
        return {img, page, idx};
    endfunction

endpackage

// File: rtl/lcd_page_buffer_if.sv
// Page handshake between the LCD controller (master) and the
// page buffer (slave).
interface lcd_page_buffer_if;
    import lcd_pkg::*;

    logic              data_request;
    logic [ADDR_W-1:0] addr;
    logic              data_ack;
    logic [7:0]        data;
    logic              busy;

    modport master (
        output data_request,
        output addr,
        input  data_ack,
        input  data,
        input  busy
    );

    modport slave (
        input  data_request,
        input  addr,
        output data_ack,
        output data,
        output busy
    );

endinterface

// File: rtl/lcd_transpose_ram.sv
// 64x8 column store: bit-scatter write of one ROM row byte,
// asynchronous read of one LCD column byte.
module lcd_transpose_ram
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [COLB_W-1:0] wr_b,
    input  logic [ROW_W-1:0]  wr_r,
    input  logic [7:0]        wr_data,
    input  logic [IDX_W-1:0]  rd_y,
    output logic [7:0]        rd_data
);

    logic [LCD_PAGE_BYTES-1:0][7:0] mem_q;
    logic [LCD_PAGE_BYTES-1:0][7:0] mem_d;

    // ROM bit 7 is the leftmost pixel, so bit j lands in column 8b+7-j.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int j = 0; j < 8; j++) begin
                mem_d[{wr_b, 3'(7 - j)}][wr_r] = wr_data[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_y];

endmodule

// File: rtl/lcd_page_buffer.sv
// Fetches one 8x64 bitmap strip from the image ROM per page request,
// transposes it and streams 64 column bytes at the controller's pace.
module lcd_page_buffer
    import lcd_pkg::*;
#(
    parameter int ROM_AW      = 13,
    parameter int BYTE_PERIOD = 2
) (
    input  logic              clk,
    input  logic              rst,
    lcd_page_buffer_if.slave  lcd,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data
);

    localparam int PH_W = (BYTE_PERIOD > 1) ? $clog2(BYTE_PERIOD) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BYTE_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LCD_PAGE_BYTES - 1);

    lcd_state_e        state_q, state_d;
    logic [IMG_W-1:0]  img_q, img_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [IDX_W-1:0]  i_q, i_d;
    logic              issued_q, issued_d;
    logic              wr_vld_q, wr_vld_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  y_q, y_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [7:0]        rd_data;

    always_comb begin
        state_d  = state_q;
        img_d    = img_q;
        page_d   = page_q;
        i_d      = i_q;
        issued_d = issued_q;
        wr_vld_d = 1'b0;
        wr_idx_d = i_q;
        y_d      = y_q;
        ph_d     = ph_q;
        unique case (state_q)
            ST_IDLE: begin
                if (lcd.data_request) begin
                    img_d    = lcd.addr[ADDR_W-1:PAGE_W];
                    page_d   = lcd.addr[PAGE_W-1:0];
                    i_d      = '0;
                    issued_d = 1'b0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Issue 64 reads, then wait for the last write to land.
                if (!issued_q) begin
                    wr_vld_d = 1'b1;
                    i_d      = i_q + 1'b1;
                    if (i_q == IDX_LAST) begin
                        issued_d = 1'b1;
                    end
                end
                if (wr_vld_q && wr_idx_q == IDX_LAST) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!lcd.data_request) begin
                    state_d = ST_STREAM;
                    y_d     = '0;
                    ph_d    = '0;
                end
            end
            ST_STREAM: begin
                if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (y_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            img_q    <= '0;
            page_q   <= '0;
            i_q      <= '0;
            issued_q <= 1'b0;
            wr_vld_q <= 1'b0;
            wr_idx_q <= '0;
            y_q      <= '0;
            ph_q     <= '0;
        end else begin
            state_q  <= state_d;
            img_q    <= img_d;
            page_q   <= page_d;
            i_q      <= i_d;
            issued_q <= issued_d;
            wr_vld_q <= wr_vld_d;
            wr_idx_q <= wr_idx_d;
            y_q      <= y_d;
            ph_q     <= ph_d;
        end
    end

    lcd_transpose_ram u_ram (
        .clk     (clk),
        .we      (wr_vld_q),
        .wr_b    (wr_idx_q[COLB_W-1:0]),
        .wr_r    (wr_idx_q[IDX_W-1:COLB_W]),
        .wr_data (rom_data),
        .rd_y    (y_q),
        .rd_data (rd_data)
    );

    assign rom_addr = (state_q == ST_FETCH && !issued_q)
                    ? ROM_AW'(rom_addr_f(img_q, page_q, i_q))
                    : '0;

    assign lcd.data_ack = (state_q == ST_ACK);
    assign lcd.busy     = (state_q != ST_IDLE);
    assign lcd.data     = (state_q == ST_STREAM) ? rd_data : 8'h00;

endmodule

// File: tb/tb_lcd_page_buffer.sv
// Scoreboard bench for lcd_page_buffer with a behavioural image ROM.
module tb_lcd_page_buffer;
    import lcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  rom [8192];
    int          cyc = 0;

    always #5 clk = ~clk;

    lcd_page_buffer_if lcd ();

    lcd_page_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .lcd      (lcd),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        cyc      <= cyc + 1;
    end

    int          pass_cnt = 0;
    int          chk_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    logic [12:0] ra_q[$];
    int          c_cyc, ack_cyc, s_cyc;
    int          ack_stream, early_fetch;
    logic        busy_last, busy_after;
    logic [7:0]  data_after;
    logic [12:0] rom_after;

    // Column y, bit r = pixel (row r, column y) of the strip.
    function automatic logic [7:0] model_byte(input logic [6:0] a, input int y);
        logic [7:0]  v;
        logic [12:0] ra;
        for (int r = 0; r < 8; r++) begin
            ra   = {a, 3'(r), 3'(y / 8)};
            v[r] = rom[ra][7 - (y % 8)];
        end
        return v;
    endfunction

    task automatic clear_rom();
        for (int k = 0; k < 8192; k++) rom[k] = 8'h00;
    endtask

    task automatic do_page(input logic [6:0] a, input int hold, input bit rereq);
        @(negedge clk);
        lcd.addr         = a;
        lcd.data_request = 1'b1;
        c_cyc            = cyc;
        for (int y = 0; y < 64; y++) exp_q.push_back(model_byte(a, y));
        ra_q.delete();
        ack_cyc = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (n < 64) ra_q.push_back(rom_addr);
            if (lcd.data_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        repeat (hold) @(negedge clk);
        lcd.data_request = 1'b0;
        s_cyc            = cyc;
        ack_stream       = 0;
        early_fetch      = 0;
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            obs_q.push_back(lcd.data);
            if (lcd.data_ack) ack_stream++;
            if (rom_addr != 13'd0) early_fetch++;
            busy_last = lcd.busy;
            if (rereq && k == 4) lcd.data_request = 1'b1;
        end
        @(negedge clk);
        busy_after = lcd.busy;
        data_after = lcd.data;
        rom_after  = rom_addr;
    endtask

    task automatic test_reset();
        lcd.data_request = 1'b0;
        lcd.addr         = '0;
        rst              = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (lcd.data_ack !== 1'b0) $display("FAIL rst_ack got %b want 0", lcd.data_ack);
        else pass_cnt++;
        chk_cnt++;
        if (lcd.data !== 8'h00) $display("FAIL rst_data got %h want 00", lcd.data);
        else pass_cnt++;
        chk_cnt++;
        if (lcd.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", lcd.busy);
        else pass_cnt++;
        chk_cnt++;
        if (rom_addr !== 13'd0) $display("FAIL rst_rom_addr got %h want 0", rom_addr);
        else pass_cnt++;

        for (int k = 0; k < 8192; k++) rom[k] = 8'($urandom);
        lcd.addr         = 7'h05;
        lcd.data_request = 1'b1;
        ack_cyc          = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (lcd.data_ack) begin
                ack_cyc = n;
                break;
            end
        end
        chk_cnt++;
        if (ack_cyc < 0) $display("FAIL rst_pre_ack got timeout want ack");
        else pass_cnt++;
        lcd.data_request = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_cnt++;
        if (lcd.data_ack !== 1'b0) $display("FAIL mid_rst_ack got %b want 0", lcd.data_ack);
        else pass_cnt++;
        chk_cnt++;
        if (lcd.data !== 8'h00) $display("FAIL mid_rst_data got %h want 00", lcd.data);
        else pass_cnt++;
        chk_cnt++;
        if (lcd.busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", lcd.busy);
        else pass_cnt++;
        ack_stream = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (lcd.busy || lcd.data != 8'h00) ack_stream++;
        end
        chk_cnt++;
        if (ack_stream !== 0) $display("FAIL mid_rst_idle got %0d active cycles want 0", ack_stream);
        else pass_cnt++;
    endtask

    task automatic test_checkerboard();
        logic [7:0] e, o;
        clear_rom();
        for (int r = 0; r < 8; r++)
            for (int b = 0; b < 8; b++)
                rom[r * 8 + b] = (r % 2 == 0) ? 8'hFF : 8'h00;
        do_page(7'h00, 0, 1'b0);
        for (int y = 0; y < 64; y++) begin
            e = exp_q.pop_front();
            chk_cnt++;
            if (e !== 8'h55) $display("FAIL chk_model y=%0d got %h want 55", y, e);
            else pass_cnt++;
            for (int h = 0; h < 2; h++) begin
                o = obs_q.pop_front();
                chk_cnt++;
                if (o !== e) $display("FAIL chk_byte y=%0d h=%0d got %h want %h", y, h, o, e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_single_pixel();
        logic [7:0] e, o;
        clear_rom();
        rom[13'h6A9] = 8'h20;
        do_page(7'h1A, 0, 1'b0);
        for (int y = 0; y < 64; y++) begin
            e = exp_q.pop_front();
            for (int h = 0; h < 2; h++) begin
                o = obs_q.pop_front();
                chk_cnt++;
                if (o !== e) $display("FAIL pix_byte y=%0d h=%0d got %h want %h", y, h, o, e);
                else pass_cnt++;
            end
        end
        for (int i = 0; i < 64; i++) begin
            chk_cnt++;
            if (ra_q[i] !== 13'h680 + 13'(i))
                $display("FAIL pix_rom_addr i=%0d got %h want %h", i, ra_q[i], 13'h680 + 13'(i));
            else pass_cnt++;
        end
    endtask

    task automatic test_handshake();
        logic [7:0] e, o;
        for (int k = 0; k < 8192; k++) rom[k] = 8'($urandom);
        do_page(7'h4B, 3, 1'b0);
        chk_cnt++;
        if (ack_cyc - c_cyc !== 66) $display("FAIL hs_ack_lat got %0d want 66", ack_cyc - c_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (s_cyc - ack_cyc !== 3) $display("FAIL hs_drop got %0d want 3", s_cyc - ack_cyc);
        else pass_cnt++;
        for (int y = 0; y < 64; y++) begin
            e = exp_q.pop_front();
            for (int h = 0; h < 2; h++) begin
                o = obs_q.pop_front();
                chk_cnt++;
                if (o !== e) $display("FAIL hs_byte y=%0d h=%0d got %h want %h", y, h, o, e);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (ack_stream !== 0) $display("FAIL hs_ack_in_stream got %0d want 0", ack_stream);
        else pass_cnt++;
        chk_cnt++;
        if (busy_last !== 1'b1) $display("FAIL hs_busy_last got %b want 1", busy_last);
        else pass_cnt++;
        chk_cnt++;
        if (busy_after !== 1'b0) $display("FAIL hs_busy_end got %b want 0", busy_after);
        else pass_cnt++;
        chk_cnt++;
        if (data_after !== 8'h00) $display("FAIL hs_data_end got %h want 00", data_after);
        else pass_cnt++;
    endtask

    task automatic test_rereq();
        logic [7:0] e, o;
        int         got;
        do_page(7'h33, 1, 1'b1);
        for (int y = 0; y < 64; y++) begin
            e = exp_q.pop_front();
            for (int h = 0; h < 2; h++) begin
                o = obs_q.pop_front();
                chk_cnt++;
                if (o !== e) $display("FAIL rq_byte y=%0d h=%0d got %h want %h", y, h, o, e);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (early_fetch !== 0) $display("FAIL rq_early_fetch got %0d want 0", early_fetch);
        else pass_cnt++;
        chk_cnt++;
        if (rom_after !== 13'd0 || busy_after !== 1'b0)
            $display("FAIL rq_idle got addr=%h busy=%b want 0/0", rom_after, busy_after);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (rom_addr !== 13'h0CC0) $display("FAIL rq_refetch got %h want 0cc0", rom_addr);
        else pass_cnt++;
        got = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (lcd.data_ack) begin
                got = 1;
                break;
            end
        end
        chk_cnt++;
        if (got !== 1) $display("FAIL rq_second_ack got timeout want ack");
        else pass_cnt++;
        lcd.data_request = 1'b0;
        repeat (135) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, o;
        for (int k = 0; k < 8192; k++) rom[k] = 8'($urandom);
        for (int p = 0; p < LCD_PAGES; p++) begin
            do_page({4'd0, 3'(p)}, p % 3, 1'b0);
            chk_cnt++;
            if (ack_stream !== 0) $display("FAIL b2b_ack p=%0d got %0d want 0", p, ack_stream);
            else pass_cnt++;
            for (int y = 0; y < 64; y++) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                chk_cnt++;
                if (o !== e) $display("FAIL b2b_byte p=%0d y=%0d got %h want %h", p, y, o, e);
                else pass_cnt++;
                o = obs_q.pop_front();
            end
        end
    endtask

    initial begin
        test_reset();
        test_checkerboard();
        test_single_pixel();
        test_handshake();
        test_rereq();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
